// File: rtl/pipe_stage2.sv
// DAL pipeline stage 2: saturating left-shift (SCALE) then arithmetic right-shift with index tagging (NORM).
// All outputs are registered, so an accepted operand appears one cycle later; stall_i freezes every register.
module pipe_stage2 #(
    parameter int W  = 16,
    parameter int SW = 4,
    parameter int CW = 8
) (
    input  logic          CLK_i,
    input  logic          RST_i,
    input  logic          stall_i,
    input  logic          stage_boundary,
    input  logic [W-1:0]  operand_i,
    input  logic [SW-1:0] scale_i,
    input  logic [CW-1:0] norm_n,
    input  logic          pos,
    output logic          finished,
    output logic          stage,
    output logic [W-1:0]  operand1_o,
    output logic [W-1:0]  operand2_o,
    output logic [1:0]    mode
);

    // Wide enough to hold the largest left shift without losing any bits.
    localparam int WIDE = W + (2 ** SW) - 1;

    localparam logic signed [WIDE-1:0] SAT_MAX = {{(WIDE-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [WIDE-1:0] SAT_MIN = {{(WIDE-W+1){1'b1}}, {(W-1){1'b0}}};

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_MUL  = 2'b01;
    localparam logic [1:0] MODE_NORM = 2'b10;

    typedef enum logic {
        ST_SCALE = 1'b0,
        ST_NORM  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] len_q, len_d;
    logic          fin_d;
    logic [1:0]    mode_d;
    logic [W-1:0]  op1_d, op2_d;

    logic signed [WIDE-1:0] op_ext;
    logic signed [WIDE-1:0] op_shl;
    logic [W-1:0]           scale_sat;
    logic signed [W-1:0]    norm_shr;

    always_comb begin
        op_ext = {{(WIDE-W){operand_i[W-1]}}, operand_i};
        op_shl = op_ext <<< scale_i;
        if (op_shl > SAT_MAX) begin
            scale_sat = {1'b0, {(W-1){1'b1}}};
        end else if (op_shl < SAT_MIN) begin
            scale_sat = {1'b1, {(W-1){1'b0}}};
        end else begin
            scale_sat = op_shl[W-1:0];
        end
        norm_shr = $signed(operand_i) >>> scale_i;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        fin_d   = 1'b0;
        mode_d  = MODE_NONE;
        op1_d   = operand1_o;
        op2_d   = operand2_o;
        if (pos) begin
            case (state_q)
                ST_SCALE: begin
                    op1_d  = scale_sat;
                    op2_d  = operand_i;
                    mode_d = MODE_MUL;
                    if (stage_boundary) begin
                        len_d   = (norm_n == '0) ? CW'(1) : norm_n;
                        cnt_d   = '0;
                        state_d = ST_NORM;
                    end
                end
                ST_NORM: begin
                    op1_d  = norm_shr;
                    op2_d  = W'(cnt_q);
                    mode_d = MODE_NORM;
                    if (cnt_q == len_q - CW'(1)) begin
                        fin_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_SCALE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = ST_SCALE;
            endcase
        end
    end

    // A stalled cycle leaves every register, outputs included, untouched.
    always_ff @(posedge CLK_i or negedge RST_i) begin
        if (!RST_i) begin
            state_q    <= ST_SCALE;
            cnt_q      <= '0;
            len_q      <= '0;
            finished   <= 1'b0;
            mode       <= MODE_NONE;
            operand1_o <= '0;
            operand2_o <= '0;
        end else if (!stall_i) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            finished   <= fin_d;
            mode       <= mode_d;
            operand1_o <= op1_d;
            operand2_o <= op2_d;
        end
    end

    assign stage = state_q;

endmodule

// File: tb/tb_pipe_stage2.sv
// Self-checking bench for pipe_stage2: directed scenarios plus a randomized run against a cycle reference model.
module tb_pipe_stage2;

    logic        CLK_i = 1'b0;
    logic        RST_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        stage_boundary = 1'b0;
    logic [15:0] operand_i = '0;
    logic [3:0]  scale_i = '0;
    logic [7:0]  norm_n = '0;
    logic        pos = 1'b0;
    logic        finished, stage;
    logic [15:0] operand1_o, operand2_o;
    logic [1:0]  mode;

    int n_cmp = 0;
    int n_err = 0;

    pipe_stage2 #(.W(16), .SW(4), .CW(8)) dut (
        .CLK_i(CLK_i), .RST_i(RST_i), .stall_i(stall_i), .stage_boundary(stage_boundary),
        .operand_i(operand_i), .scale_i(scale_i), .norm_n(norm_n), .pos(pos),
        .finished(finished), .stage(stage), .operand1_o(operand1_o),
        .operand2_o(operand2_o), .mode(mode)
    );

    always #5 CLK_i = ~CLK_i;

    // {finished, stage, mode, operand1_o, operand2_o}
    function automatic logic [36:0] obs();
        return {finished, stage, mode, operand1_o, operand2_o};
    endfunction

    function automatic logic [36:0] pack(logic f, logic s, logic [1:0] m, logic [15:0] a, logic [15:0] b);
        return {f, s, m, a, b};
    endfunction

    function automatic logic [15:0] sat_ref(logic [15:0] op, int sc);
        longint v;
        v = longint'($signed(op)) * (longint'(1) << sc);
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    function automatic logic [15:0] shr_ref(logic [15:0] op, int sc);
        longint v;
        v = longint'($signed(op));
        v = v >>> sc;
        return v[15:0];
    endfunction

    task automatic tick();
        @(posedge CLK_i);
        #1;
    endtask

    task automatic drive(logic st, logic p, logic bnd, logic [15:0] op, logic [3:0] sc, logic [7:0] nn);
        stall_i = st; pos = p; stage_boundary = bnd; operand_i = op; scale_i = sc; norm_n = nn;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 16'h0, 4'h0, 8'h0);
        #2 RST_i = 1'b0;
        #3 RST_i = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [36:0] exp_v;
        do_reset();
        exp_v = pack(0, 0, 2'b00, 16'h0, 16'h0);
        n_cmp++;
        if (obs() !== exp_v) begin n_err++; $display("FAIL reset_initial got=%h exp=%h", obs(), exp_v); end
        drive(0, 1, 1, 16'h0011, 4'd0, 8'd3); tick();
        drive(0, 1, 0, 16'h0020, 4'd1, 8'd0); tick();
        exp_v = pack(0, 1, 2'b10, 16'h0010, 16'h0000);
        n_cmp++;
        if (obs() !== exp_v) begin n_err++; $display("FAIL reset_pre_norm got=%h exp=%h", obs(), exp_v); end
        drive(0, 0, 0, 16'h0, 4'h0, 8'h0);
        #2 RST_i = 1'b0;
        #1;
        exp_v = pack(0, 0, 2'b00, 16'h0, 16'h0);
        n_cmp++;
        if (obs() !== exp_v) begin n_err++; $display("FAIL reset_async got=%h exp=%h", obs(), exp_v); end
        #2 RST_i = 1'b1;
        tick();
        drive(0, 1, 0, 16'h0005, 4'd1, 8'd0); tick();
        exp_v = pack(0, 0, 2'b01, 16'h000A, 16'h0005);
        n_cmp++;
        if (obs() !== exp_v) begin n_err++; $display("FAIL reset_first_scale got=%h exp=%h", obs(), exp_v); end
    endtask

    task automatic test_scale();
        logic [36:0] exp_v;
        drive(0, 1, 0, 16'h0003, 4'd2, 8'd0); tick();
        exp_v = pack(0, 0, 2'b01, 16'h000C, 16'h0003);
        n_cmp++;
        if (obs() !== exp_v) begin n_err++; $display("FAIL scale_basic got=%h exp=%h", obs(), exp_v); end
    endtask

    task automatic test_saturation();
        logic [15:0] ops [4] = '{16'h4000, 16'hC000, 16'h0001, 16'h0000};
        logic [3:0]  scs [4] = '{4'd2, 4'd2, 4'd15, 4'd15};
        logic [15:0] exps[4] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, ops[i], scs[i], 8'd0); tick();
            n_cmp++;
            if (operand1_o !== exps[i] || mode !== 2'b01) begin
                n_err++;
                $display("FAIL saturation_%0d got op1=%h mode=%b exp op1=%h mode=01", i, operand1_o, mode, exps[i]);
            end
        end
    endtask

    task automatic test_phase_switch();
        logic [36:0] exp_v;
        drive(0, 1, 1, 16'h0001, 4'd0, 8'd3); tick();
        exp_v = pack(0, 1, 2'b01, 16'h0001, 16'h0001);
        n_cmp++;
        if (obs() !== exp_v) begin n_err++; $display("FAIL phase_boundary got=%h exp=%h", obs(), exp_v); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 16'hFF00, 4'd4, 8'd7); tick();
            exp_v = pack(i == 2, i < 2, 2'b10, 16'hFFF0, 16'(i));
            n_cmp++;
            if (obs() !== exp_v) begin n_err++; $display("FAIL phase_norm_%0d got=%h exp=%h", i, obs(), exp_v); end
        end
        drive(0, 1, 0, 16'h0002, 4'd1, 8'd0); tick();
        exp_v = pack(0, 0, 2'b01, 16'h0004, 16'h0002);
        n_cmp++;
        if (obs() !== exp_v) begin n_err++; $display("FAIL phase_back_scale got=%h exp=%h", obs(), exp_v); end
    endtask

    task automatic test_stall();
        logic [36:0] exp_v;
        drive(0, 1, 1, 16'h0000, 4'd0, 8'd3); tick();
        drive(0, 1, 0, 16'h8000, 4'd1, 8'd0); tick();
        exp_v = pack(0, 1, 2'b10, 16'hC000, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 16'h1234, 4'd3, 8'd9); tick();
            n_cmp++;
            if (obs() !== exp_v) begin n_err++; $display("FAIL stall_hold_%0d got=%h exp=%h", i, obs(), exp_v); end
        end
        drive(0, 0, 0, 16'h5555, 4'd3, 8'd0); tick();
        exp_v = pack(0, 1, 2'b00, 16'hC000, 16'h0000);
        n_cmp++;
        if (obs() !== exp_v) begin n_err++; $display("FAIL strobe_idle got=%h exp=%h", obs(), exp_v); end
        drive(0, 1, 0, 16'h0100, 4'd8, 8'd0); tick();
        exp_v = pack(0, 1, 2'b10, 16'h0001, 16'h0001);
        n_cmp++;
        if (obs() !== exp_v) begin n_err++; $display("FAIL stall_counter got=%h exp=%h", obs(), exp_v); end
        drive(0, 1, 0, 16'h0100, 4'd8, 8'd0); tick();
        exp_v = pack(1, 0, 2'b10, 16'h0001, 16'h0002);
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 16'h7777, 4'd1, 8'd0); tick();
            n_cmp++;
            if (obs() !== exp_v) begin n_err++; $display("FAIL stall_finished_%0d got=%h exp=%h", i, obs(), exp_v); end
        end
        drive(0, 0, 0, 16'h0, 4'd0, 8'd0); tick();
        exp_v = pack(0, 0, 2'b00, 16'h0001, 16'h0002);
        n_cmp++;
        if (obs() !== exp_v) begin n_err++; $display("FAIL finished_clear got=%h exp=%h", obs(), exp_v); end
    endtask

    task automatic test_norm_zero();
        logic [36:0] exp_v;
        drive(0, 1, 1, 16'h0003, 4'd0, 8'd0); tick();
        drive(0, 1, 1, 16'h0040, 4'd3, 8'd0); tick();
        exp_v = pack(1, 0, 2'b10, 16'h0008, 16'h0000);
        n_cmp++;
        if (obs() !== exp_v) begin n_err++; $display("FAIL norm_zero got=%h exp=%h", obs(), exp_v); end
        drive(0, 1, 0, 16'h0002, 4'd1, 8'd0); tick();
        exp_v = pack(0, 0, 2'b01, 16'h0004, 16'h0002);
        n_cmp++;
        if (obs() !== exp_v) begin n_err++; $display("FAIL norm_zero_after got=%h exp=%h", obs(), exp_v); end
    endtask

    task automatic test_random();
        logic        m_stage = 0, m_fin = 0;
        logic [1:0]  m_mode = 0;
        logic [15:0] m_op1 = 0, m_op2 = 0;
        int          m_cnt = 0, m_len = 0;
        logic [36:0] exp_v;
        logic st, p, bnd;
        logic [15:0] op;
        logic [3:0] sc;
        logic [7:0] nn;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            st  = ($urandom_range(0, 3) == 0);
            p   = ($urandom_range(0, 9) < 7);
            bnd = ($urandom_range(0, 6) == 0);
            op  = 16'($urandom);
            sc  = 4'($urandom);
            nn  = 8'($urandom_range(0, 5));
            drive(st, p, bnd, op, sc, nn);
            if (!st) begin
                if (!p) begin
                    m_mode = 2'b00; m_fin = 0;
                end else if (!m_stage) begin
                    m_op1 = sat_ref(op, int'(sc)); m_op2 = op; m_mode = 2'b01; m_fin = 0;
                    if (bnd) begin
                        m_len = (nn == 0) ? 1 : int'(nn); m_cnt = 0; m_stage = 1;
                    end
                end else begin
                    m_op1 = shr_ref(op, int'(sc)); m_op2 = 16'(m_cnt); m_mode = 2'b10;
                    if (m_cnt == m_len - 1) begin
                        m_fin = 1; m_cnt = 0; m_stage = 0;
                    end else begin
                        m_fin = 0; m_cnt++;
                    end
                end
            end
            tick();
            exp_v = pack(m_fin, m_stage, m_mode, m_op1, m_op2);
            n_cmp++;
            if (obs() !== exp_v) begin n_err++; $display("FAIL random_c%0d got=%h exp=%h", c, obs(), exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_scale();
        test_saturation();
        test_phase_switch();
        test_stall();
        test_norm_zero();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
